frame_fifo_arbiter: RTL
=======================

FRAME_FIFO_ARBITER -- requirements
Module: frame_fifo_arbiter

Interface
REQ-001 Parameter DWIDTH, default 32, per-colour-channel width; the pixel word is DWIDTH*3 bits.
REQ-002 Parameter NUM_SRC, default 2, number of pixel sources (legal range 2..4).
REQ-003 clock  input  1  the single clock; all logic is rising-edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 src_req  input  NUM_SRC  per-source frame request, held high until frame_done for that source.
REQ-006 src_len  input  NUM_SRC*32  per-source frame length in words, valid while src_req is high.
REQ-007 src_data  input  NUM_SRC*DWIDTH*3  per-source pixel word.
REQ-008 src_valid  input  NUM_SRC  per-source pixel word valid.
REQ-009 src_ready  output  NUM_SRC  per-source word accept.
REQ-010 fifo_full  input  1  downstream almost-full; asserted while at most 1 free entry remains.
REQ-011 fifo_data  output  DWIDTH*3  registered pixel word to the FIFO.
REQ-012 fifo_wrreq  output  1  registered FIFO write strobe.
REQ-013 grant  output  NUM_SRC  one-hot current owner, all-zero when idle.
REQ-014 frame_done  output  NUM_SRC  one-cycle pulse when the owner's frame completes.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, XFER and DONE.
REQ-017 IDLE: if any src_req is high, select a source round-robin starting at the index after last_owner, set grant, and go to LOAD.
REQ-018 LOAD: latch src_len[owner] into a 32-bit remaining counter; go to DONE if the value is 0, else to XFER.
REQ-019 XFER: src_ready[owner] = !fifo_full; all other src_ready bits are 0; src_ready is combinational from the state, grant and fifo_full.
REQ-020 A beat SHALL be accepted when src_valid[owner] && src_ready[owner].
- next cycle: fifo_wrreq=1 and fifo_data = that word (1-cycle latency).
- on cycles without an accepted beat: fifo_wrreq=0 and fifo_data holds its last value.
REQ-021 Each accepted beat SHALL decrement remaining; the beat that makes remaining 0 moves the FSM to DONE in the same edge.
REQ-022 DONE: pulse frame_done[owner] for one cycle, update last_owner, clear grant, and return to IDLE.
REQ-023 A source whose src_req is still high after DONE is eligible again; round-robin ensures other requesters are served first.
REQ-024 src_req deasserted by the owner mid-frame SHALL be ignored; the frame runs to its length.
REQ-025 src_len changes after LOAD SHALL have no effect on the current frame.
REQ-026 fifo_full asserted mid-frame SHALL stall acceptance with no beat lost or duplicated; transfer resumes the cycle after it clears.
REQ-027 Invalid source-index wrap SHALL be modulo NUM_SRC.

Reset
REQ-028 reset_n low SHALL asynchronously force:
- state = IDLE;
- grant, src_ready, frame_done, fifo_wrreq, busy = 0;
- fifo_data = 0, remaining = 0;
- last_owner = NUM_SRC-1, so source 0 wins first.
REQ-029 Reset mid-frame SHALL abandon the frame without issuing frame_done; release is synchronous to clock.

Structure
REQ-030 A shared package SHALL hold the state encoding constants (IDLE=0, LOAD=1, XFER=2, DONE=3) and the pixel width expression DWIDTH*3.
REQ-031 Round-robin selection SHALL be a sub-module rr_select (inputs: request vector, last_owner; output: one-hot grant plus index), combinational.

Verification
REQ-032 Single source: src_req[0]=1, src_len=4, always valid, fifo_full=0 -> 4 fifo_wrreq pulses with words in order, frame_done[0] 1 cycle after the last beat, then busy=0.
REQ-033 Contention: both sources request with len=3 from reset -> source 0 frame (3 words), then source 1 frame (3 words), with no interleaving and grant one-hot throughout.
REQ-034 Backpressure: len=8, fifo_full high for 5 cycles after the 3rd beat -> exactly 8 writes, no duplicates, src_ready low during the stall.
REQ-035 Zero length: src_len=0 -> LOAD to DONE, frame_done pulse, 0 writes.
REQ-036 Reset mid-frame: reset_n low after beat 2 of 6 -> all outputs 0 immediately, no frame_done; after release source 0 is re-granted and 6 beats are written.
REQ-037 Source bubbles: src_valid toggling 1/0 with len=5 -> 5 writes at a 1-cycle latency from each accept.

Source files
------------

// File: rtl/frame_fifo_arbiter_pkg.sv
// frame_fifo_arbiter_pkg: state encoding, length width and pixel width helper shared by the arbiter
package frame_fifo_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int LEN_W = 32;

    function automatic int pix_w(input int dwidth);
        return dwidth * 3;
    endfunction

endpackage

// File: rtl/frame_fifo_arbiter_rr_select.sv
// rr_select: combinational round-robin pick, first requester after last owner, wrapping modulo N
module rr_select #(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] c;

    // Walk from the farthest candidate back to the nearest so the nearest requester wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        c = '0;
        for (int k = N; k >= 1; k--) begin
            c = IW'((int'(last) + k) % N);
            if (req[c]) begin
                gnt = '0;
                gnt[c] = 1'b1;
                idx = c;
            end
        end
    end

endmodule

// File: rtl/frame_fifo_arbiter.sv
// frame_fifo_arbiter: grants whole frames from NUM_SRC pixel sources round-robin into one FIFO write port
module frame_fifo_arbiter
    import frame_fifo_arbiter_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int NUM_SRC = 2,
    localparam int PW = pix_w(DWIDTH),
    localparam int IW = $clog2(NUM_SRC)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_SRC-1:0]       src_req,
    input  logic [NUM_SRC*LEN_W-1:0] src_len,
    input  logic [NUM_SRC*PW-1:0]    src_data,
    input  logic [NUM_SRC-1:0]       src_valid,
    output logic [NUM_SRC-1:0]       src_ready,
    input  logic                     fifo_full,
    output logic [PW-1:0]            fifo_data,
    output logic                     fifo_wrreq,
    output logic [NUM_SRC-1:0]       grant,
    output logic [NUM_SRC-1:0]       frame_done,
    output logic                     busy
);

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d, done_q, done_d, rr_gnt;
    logic [IW-1:0]      owner_q, owner_d, last_q, last_d, rr_idx;
    logic [LEN_W-1:0]   rem_q, rem_d, owner_len;
    logic [PW-1:0]      data_q, data_d;
    logic               wr_q, wr_d, accept;

    rr_select #(.N(NUM_SRC)) u_rr (
        .req  (src_req),
        .last (last_q),
        .gnt  (rr_gnt),
        .idx  (rr_idx)
    );

    assign owner_len = src_len[owner_q*LEN_W +: LEN_W];
    assign src_ready = (state_q == XFER && !fifo_full) ? grant_q : '0;
    assign accept    = |(src_valid & src_ready);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        rem_d   = rem_q;
        done_d  = '0;
        wr_d    = accept;
        data_d  = accept ? src_data[owner_q*PW +: PW] : data_q;
        case (state_q)
            IDLE: if (|src_req) begin
                grant_d = rr_gnt;
                owner_d = rr_idx;
                state_d = LOAD;
            end
            LOAD: begin
                rem_d   = owner_len;
                state_d = (owner_len == '0) ? DONE : XFER;
            end
            XFER: if (accept) begin
                rem_d   = rem_q - LEN_W'(1);
                state_d = (rem_q == LEN_W'(1)) ? DONE : XFER;
            end
            DONE: begin
                done_d  = grant_q;
                last_d  = owner_q;
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IW'(NUM_SRC - 1);
            rem_q   <= '0;
            done_q  <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
        end
    end

    assign grant      = grant_q;
    assign frame_done = done_q;
    assign fifo_wrreq = wr_q;
    assign fifo_data  = data_q;
    assign busy       = (state_q != IDLE);

endmodule
